// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction prefetcher. Streams a run of instruction words
// from DDR over AXI4 read bursts into a first-word-fall-through FIFO that
// feeds the decoder through a valid/ready port. Bursts never cross a 4KB page,
// never exceed MAX_BURST beats and are only issued when the FIFO has room for
// every beat already in flight plus the new burst, so R data is always
// accepted. Up to MAX_OUTST bursts may be outstanding.
// Optional feature: define INST_FETCH_ABORT_EN to add an abort input that
// cancels a running fetch, discards its in-flight data and flushes the FIFO.
module inst_fetch_ctrl #(
  parameter int ID_W       = 10,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 24,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_OUTST  = 2,
  parameter int ARID_VAL   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_cmptd,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef INST_FETCH_ABORT_EN
  input  logic              abort,
`endif
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, next_state;
  logic              soft_rst;
  logic              start_q;
  logic              launch;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [CW-1:0]     reserved;
  logic [CW-1:0]     count;
  logic [2:0]        outst;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic              zero_done_q;
  logic              rd_err_q;
  logic [12:0]       page_beats;
  logic [8:0]        burst_beats;
  logic [8:0]        held_beats;
  logic              credit_ok;
  logic              want_ar;
  logic              ar_fire, r_fire, push, pop;
  logic              last_ar;
  logic              drain_exit;
  logic              flush;
  logic              abort_req;
  logic              aborted_q;
  logic              unused_ok;

  // Losing DDR calibration is treated exactly like a reset.
  assign soft_rst  = !rst_n || !init_cmptd;
  assign launch    = (state == IDLE) && start && !start_q;

  // The read ID is never checked; this just keeps it from looking forgotten.
  assign unused_ok = ^axi_rid;

  // Burst sizing: the smallest of the beats left, MAX_BURST and the room to the page end.
  assign page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
  always_comb begin
    burst_beats = 9'(MAX_BURST);
    if (32'(page_beats) < 32'(burst_beats)) burst_beats = 9'(page_beats);
    if (32'(remaining) < 32'(burst_beats)) burst_beats = 9'(remaining);
  end

  assign held_beats = {1'b0, arlen_q} + 9'd1;
  assign credit_ok  = (outst < 3'(MAX_OUTST)) &&
                      (32'(count) + 32'(reserved) + 32'(burst_beats) <= 32'(FIFO_DEPTH));
  assign want_ar    = (state == ISSUE) && !arvalid_q && (remaining != '0) &&
                      !aborted_q && !abort_req && credit_ok;

  assign ar_fire    = arvalid_q && axi_arready;
  assign r_fire     = axi_rvalid && axi_rready;
  assign pop        = out_valid && out_ready;
  assign push       = r_fire && !aborted_q && !abort_req;
  assign last_ar    = ar_fire && (aborted_q || abort_req || (32'(remaining) == 32'(held_beats)));
  assign drain_exit = (outst == 3'd0) || (r_fire && axi_rlast && (outst == 3'd1));

`ifdef INST_FETCH_ABORT_EN
  assign abort_req = abort && (state != IDLE);

  // Remembers that the running fetch was cancelled until its last beat has drained.
  always_ff @(posedge clk) begin
    if (soft_rst) aborted_q <= 1'b0;
    else if (abort_req) aborted_q <= 1'b1;
    else if (state == DRAIN && drain_exit) aborted_q <= 1'b0;
  end
`else
  assign abort_req = 1'b0;
  assign aborted_q = 1'b0;
`endif

  assign flush = abort_req || (aborted_q && (state == DRAIN) && drain_exit);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (soft_rst) state <= IDLE;
    else state <= next_state;
  end

  // FSM next state: issue bursts, then wait for the last outstanding beat.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (launch && (len != '0)) next_state = ISSUE;
      ISSUE: begin
        if (last_ar) next_state = DRAIN;
        else if ((abort_req || aborted_q) && !arvalid_q) next_state = DRAIN;
      end
      DRAIN: if (drain_exit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Fetch bookkeeping: address/length walk, AR request, credits and error flag.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      start_q     <= 1'b0;
      zero_done_q <= 1'b0;
      rd_err_q    <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      reserved    <= '0;
      outst       <= '0;
    end else begin
      start_q     <= start;
      zero_done_q <= launch && (len == '0);
      if (launch) begin
        rd_err_q  <= 1'b0;
        addr      <= start_addr;
        remaining <= len;
      end else begin
        if (r_fire && (axi_rresp != 2'b00)) rd_err_q <= 1'b1;
        if (want_ar) begin
          arvalid_q <= 1'b1;
          araddr_q  <= addr;
          arlen_q   <= 8'(burst_beats - 9'd1);
        end
        if (ar_fire) begin
          arvalid_q <= 1'b0;
          addr      <= addr + (ADDR_W'(held_beats) << SZ);
          if (!aborted_q && !abort_req) remaining <= remaining - LEN_W'(held_beats);
        end
        if (abort_req) remaining <= '0;
      end
      reserved <= reserved + (ar_fire ? CW'(held_beats) : CW'(0)) - CW'(r_fire);
      outst    <= outst + 3'(ar_fire) - 3'(r_fire && axi_rlast);
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count as is.
  always_ff @(posedge clk) begin
    if (soft_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi_rdata;
  end

  assign axi_arid    = ID_W'(ARID_VAL);
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = 3'(SZ);
  assign axi_arburst = {1'b0, arvalid_q};
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = busy;
  assign busy        = (state != IDLE);
  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign done        = zero_done_q || ((state == DRAIN) && drain_exit && !aborted_q && !abort_req);
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: scoreboard bench for inst_fetch_ctrl with a behavioural
// AXI read slave. Tests push expected AR requests and instruction words into
// queues; monitors pop and compare whenever the DUT hands something over.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_cmptd;
  logic        start;
  logic [31:0] start_addr;
  logic [23:0] len;
  logic [9:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [9:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        rd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ar_cnt   = 0;
  int outst_b  = 0;
  int max_outst = 0;
  int cyc      = 0;
  int ar_delay = 0;
  int r_lat    = 2;
  int err_beat = -1;
  int fetch_beat = 0;

  logic [31:0] exp_q[$];
  logic [39:0] ar_exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          ready_at;
  } burst_t;
  burst_t bq[$];

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_cmptd(init_cmptd), .start(start),
    .start_addr(start_addr), .len(len),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI read slave model: samples handshakes mid-cycle, updates just after the edge.
  initial begin : slave
    logic        s_ar_fire, s_arvalid, s_r_fire, s_rlast, s_rst;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    int          beat_idx;
    int          wcnt;
    beat_idx = 0;
    wcnt = 0;
    axi_arready = 1'b1;
    axi_rvalid = 1'b0;
    axi_rlast = 1'b0;
    axi_rresp = 2'b00;
    axi_rdata = '0;
    axi_rid = '0;
    forever begin
      @(negedge clk);
      s_ar_fire = axi_arvalid && axi_arready;
      s_arvalid = axi_arvalid;
      s_araddr  = axi_araddr;
      s_arlen   = axi_arlen;
      s_r_fire  = axi_rvalid && axi_rready;
      s_rlast   = axi_rlast;
      s_rst     = !rst_n;
      @(posedge clk);
      #1;
      if (s_rst) begin
        bq.delete();
        beat_idx = 0;
        wcnt = 0;
        axi_rvalid = 1'b0;
        axi_rlast = 1'b0;
        axi_rresp = 2'b00;
        axi_arready = (ar_delay == 0);
      end else begin
        if (s_ar_fire) bq.push_back('{s_araddr, int'(s_arlen) + 1, cyc + r_lat});
        if (s_r_fire) begin
          fetch_beat++;
          if (s_rlast) begin
            if (bq.size() > 0) void'(bq.pop_front());
            beat_idx = 0;
          end else beat_idx++;
        end
        if (ar_delay == 0) axi_arready = 1'b1;
        else if (s_ar_fire || !s_arvalid) begin
          axi_arready = 1'b0;
          wcnt = 0;
        end else begin
          wcnt++;
          axi_arready = (wcnt >= ar_delay);
        end
        if (bq.size() > 0 && cyc >= bq[0].ready_at) begin
          axi_rvalid = 1'b1;
          axi_rdata  = mem_word(bq[0].addr + 32'(4 * beat_idx));
          axi_rlast  = (beat_idx == bq[0].beats - 1);
          axi_rresp  = (fetch_beat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi_rvalid = 1'b0;
          axi_rlast  = 1'b0;
          axi_rresp  = 2'b00;
        end
      end
    end
  end

  // Monitor: checks AR requests, AR stability, delivered words; counts done and bursts in flight.
  initial begin : monitor
    logic        prev_wait;
    logic [39:0] prev_ar;
    prev_wait = 1'b0;
    prev_ar = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wait = 1'b0;
        outst_b = 0;
      end else begin
        if (prev_wait) check_output("ar_stable", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, prev_ar});
        prev_wait = axi_arvalid && !axi_arready;
        prev_ar = {axi_araddr, axi_arlen};
        if (axi_arvalid && axi_arready) begin
          ar_cnt++;
          outst_b++;
          if (ar_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ar_extra: got %0h/%0d expected none", axi_araddr, axi_arlen);
          end else check_output("ar_req", {axi_araddr, axi_arlen}, ar_exp_q.pop_front());
        end
        if (axi_rvalid && axi_rready && axi_rlast) outst_b--;
        if (outst_b > max_outst) max_outst = outst_b;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL data_extra: got %0h expected none", out_data);
          end else check_output("data", out_data, exp_q.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [23:0] n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(a + 32'(4 * i)));
    @(posedge clk);
    #1;
    start_addr = a;
    len = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && ar_exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got busy=%0d words_left=%0d expected idle", tag, busy, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    int d0;
    int a0;
    rst_n = 1'b0;
    init_cmptd = 1'b1;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_outputs", {axi_arvalid, axi_rready, out_valid, busy, done, rd_err},
                 6'b0);
    check_output("rst_ar", {axi_araddr, axi_arlen, axi_arburst}, 42'h0);
    check_output("rst_arsize", axi_arsize, 3'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] test 1: len 40 at 0x1000");
    d0 = done_cnt;
    ar_exp_q.push_back({32'h1000, 8'd15});
    ar_exp_q.push_back({32'h1040, 8'd15});
    ar_exp_q.push_back({32'h1080, 8'd7});
    apply_stimulus(32'h1000, 24'd40);
    wait_idle(2000, "t1");
    check_output("t1_done", done_cnt - d0, 1);

    $display("[TB] test 2: 4KB boundary at 0x1FF0");
    d0 = done_cnt;
    ar_exp_q.push_back({32'h1FF0, 8'd3});
    ar_exp_q.push_back({32'h2000, 8'd3});
    apply_stimulus(32'h1FF0, 24'd8);
    wait_idle(2000, "t2");
    check_output("t2_done", done_cnt - d0, 1);

    $display("[TB] test 2b: len 0");
    d0 = done_cnt;
    a0 = ar_cnt;
    apply_stimulus(32'h7000, 24'd0);
    @(negedge clk);
    check_output("len0_busy", busy, 0);
    wait_idle(50, "t2b");
    check_output("len0_done", done_cnt - d0, 1);
    check_output("len0_no_ar", ar_cnt - a0, 0);

    $display("[TB] test 3: credit stall with out_ready low, len 200");
    out_ready = 1'b0;
    d0 = done_cnt;
    a0 = ar_cnt;
    for (int k = 0; k < 12; k++) ar_exp_q.push_back({32'(64 * k), 8'd15});
    ar_exp_q.push_back({32'd768, 8'd7});
    apply_stimulus(32'h0, 24'd200);
    repeat (300) @(negedge clk);
    check_output("t3_stall_bursts", ar_cnt - a0, 4);
    check_output("t3_out_valid", out_valid, 1);
    check_output("t3_busy", busy, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(4000, "t3");
    check_output("t3_done", done_cnt - d0, 1);

    $display("[TB] test 4: slow arready, long read latency");
    ar_delay = 5;
    r_lat = 20;
    max_outst = 0;
    d0 = done_cnt;
    ar_exp_q.push_back({32'h3000, 8'd15});
    ar_exp_q.push_back({32'h3040, 8'd15});
    ar_exp_q.push_back({32'h3080, 8'd7});
    apply_stimulus(32'h3000, 24'd40);
    wait_idle(4000, "t4");
    check_output("t4_max_outst", max_outst, 2);
    check_output("t4_done", done_cnt - d0, 1);
    ar_delay = 0;
    r_lat = 2;
    repeat (3) @(negedge clk);

    $display("[TB] test 5: error response on beat 3");
    d0 = done_cnt;
    err_beat = fetch_beat + 3;
    ar_exp_q.push_back({32'h4000, 8'd7});
    apply_stimulus(32'h4000, 24'd8);
    wait_idle(2000, "t5");
    err_beat = -1;
    check_output("t5_rd_err", rd_err, 1);
    check_output("t5_done", done_cnt - d0, 1);
    repeat (5) @(negedge clk);
    check_output("t5_rd_err_sticky", rd_err, 1);

    $display("[TB] test 6: reset mid-fetch then fresh len 4");
    ar_exp_q.push_back({32'h5000, 8'd15});
    ar_exp_q.push_back({32'h5040, 8'd15});
    ar_exp_q.push_back({32'h5080, 8'd7});
    apply_stimulus(32'h5000, 24'd40);
    @(negedge clk);
    check_output("t6_rd_err_cleared", rd_err, 0);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() <= 34) break;
      @(negedge clk);
    end
    check_output("t6_busy_before_rst", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    ar_exp_q.delete();
    repeat (2) @(negedge clk);
    check_output("t6_rst_outputs", {axi_arvalid, axi_rready, out_valid, busy, done, rd_err},
                 6'b0);
    check_output("t6_rst_ar", {axi_araddr, axi_arlen, out_data}, 72'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("t6_after_rst_empty", out_valid, 0);
    d0 = done_cnt;
    ar_exp_q.push_back({32'h6000, 8'd3});
    apply_stimulus(32'h6000, 24'd4);
    wait_idle(2000, "t6");
    check_output("t6_done", done_cnt - d0, 1);
    check_output("t6_fifo_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
